// File: rtl/gtp_link_pkg.sv
// Shared definitions for the 16-bit GTP lane framer and deframer.
// Holds the K/D character codes, the fixed control words and the link
// state enumeration, so both link ends agree on the framing.
package gtp_link_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] D16_2 = 8'h50;

  // Control words carry the K character in the low byte only.
  localparam logic [15:0] IDLE_W = {D16_2, K28_5};
  localparam logic [15:0] EOF_W  = {8'h00, K29_7};

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StChk,
    StEof,
    StGap
  } link_state_e;

  // Start-of-frame word: sequence number in the high byte, K27.7 in the low byte.
  function automatic logic [15:0] sof_word(input logic [7:0] seq);
    return {seq, K27_7};
  endfunction

endpackage

// File: rtl/gtp_tx_framer.sv
// Transmit framer for one 16-bit GTP lane.
// Wraps a valid/ready payload stream into SOF / payload / checksum / EOF frames
// and fills every other word with comma idles so the receiver keeps alignment.
//
// Ports:
//   clk         lane user clock
//   rst_n       synchronous active-low reset
//   en          link enable; gates the start of new frames only
//   s_data      payload word
//   s_valid     payload word valid
//   s_last      final payload word of a frame
//   s_ready     payload accepted on s_valid & s_ready (combinational)
//   tx_data     word to GTP TXDATA (registered)
//   tx_charisk  K flag for the low byte (registered)
//   busy        high while SOF..EOF is on tx_data (registered)
//   trunc       one-cycle pulse with the word that hits MAX_LEN without s_last
module gtp_tx_framer
  import gtp_link_pkg::*;
#(
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned MIN_GAP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [15:0] tx_data,
  output logic        tx_charisk,
  output logic        busy,
  output logic        trunc
);

  localparam int unsigned CntW = $clog2(MAX_LEN + 1);
  localparam int unsigned GapW = $clog2(MIN_GAP + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_LEN);
  localparam logic [GapW-1:0] GapLoad = GapW'(MIN_GAP);
  localparam logic [GapW-1:0] GapOne  = GapW'(1);

  link_state_e     state_q, state_d;
  logic [7:0]      seq_q, seq_d;
  logic [15:0]     chk_q, chk_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            drop_q, drop_d;

  logic [15:0]     tx_data_q, tx_data_d;
  logic            tx_k_q, tx_k_d;
  logic            busy_q, busy_d;
  logic            trunc_q, trunc_d;

  logic            start;
  logic            hs;
  logic [CntW-1:0] cnt_inc;
  logic            hit_max;

  // A pending drop blocks frame start so the tail of a truncated frame is never
  // mistaken for the head of the next one.
  assign start   = (state_q == StIdle) && en && s_valid && !drop_q;
  assign hs      = s_valid && s_ready;
  assign cnt_inc = cnt_q + 1'b1;
  assign hit_max = (cnt_inc == MaxCnt);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StGap;
      seq_q     <= 8'd0;
      chk_q     <= 16'd0;
      cnt_q     <= '0;
      gap_q     <= GapLoad;
      drop_q    <= 1'b0;
      tx_data_q <= IDLE_W;
      tx_k_q    <= 1'b1;
      busy_q    <= 1'b0;
      trunc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      chk_q     <= chk_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      drop_q    <= drop_d;
      tx_data_q <= tx_data_d;
      tx_k_q    <= tx_k_d;
      busy_q    <= busy_d;
      trunc_q   <= trunc_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    chk_d   = chk_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    drop_d  = drop_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StData;
          seq_d   = seq_q + 8'd1;
          chk_d   = 16'd0;
          cnt_d   = '0;
        end
      end
      StData: begin
        if (hs) begin
          chk_d = chk_q + s_data;
          cnt_d = cnt_inc;
          if (s_last || hit_max) state_d = StChk;
          if (hit_max && !s_last) drop_d = 1'b1;
        end
      end
      StChk: state_d = StEof;
      StEof: begin
        state_d = StGap;
        gap_d   = GapLoad;
      end
      StGap: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GapOne) state_d = StIdle;
      end
      default: state_d = StGap;
    endcase
    // Discarded words outside DATA: the final one ends the drop.
    if (drop_q && hs && s_last && (state_q != StData)) drop_d = 1'b0;
  end

  // Outputs: s_ready directly, the rest as next values for the output flops.
  always_comb begin
    s_ready   = (state_q == StData) || drop_q;
    tx_data_d = IDLE_W;
    tx_k_d    = 1'b1;
    busy_d    = 1'b0;
    trunc_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          tx_data_d = sof_word(seq_q);
          busy_d    = 1'b1;
        end
      end
      StData: begin
        busy_d = 1'b1;
        // No handshake leaves IDLE_W as in-frame fill.
        if (hs) begin
          tx_data_d = s_data;
          tx_k_d    = 1'b0;
          trunc_d   = hit_max && !s_last;
        end
      end
      StChk: begin
        tx_data_d = chk_q;
        tx_k_d    = 1'b0;
        busy_d    = 1'b1;
      end
      StEof: begin
        tx_data_d = EOF_W;
        busy_d    = 1'b1;
      end
      StGap: ;
      default: ;
    endcase
  end

  assign tx_data    = tx_data_q;
  assign tx_charisk = tx_k_q;
  assign busy       = busy_q;
  assign trunc      = trunc_q;

endmodule

// File: tb/tb_gtp_tx_framer.sv
// Bench for gtp_tx_framer: table-driven directed frames, hand-written corner
// sequences (truncation, reset abort) and randomized frames checked by a
// frame-level reference model.
module tb_gtp_tx_framer;

  localparam int unsigned MaxLen = 4;
  localparam int unsigned MinGap = 4;
  localparam logic [15:0] IdleW  = 16'h50BC;
  localparam logic [15:0] EofW   = 16'h00FD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] s_data = 16'h0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [15:0] tx_data;
  logic        tx_charisk;
  logic        busy;
  logic        trunc;

  int checks = 0;
  int errors = 0;

  always #4 clk = ~clk;

  gtp_tx_framer #(
    .MAX_LEN(MaxLen),
    .MIN_GAP(MinGap)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .tx_data   (tx_data),
    .tx_charisk(tx_charisk),
    .busy      (busy),
    .trunc     (trunc)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Directed vectors: outputs sampled at a falling edge, then inputs driven.
  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic        l;
    logic [15:0] ed;
    logic        ek;
    logic        er;
    logic        eb;
    logic        et;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic l,
                              input logic [15:0] ed, input logic ek, input logic er,
                              input logic eb, input logic et);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.ed = ed; r.ek = ek; r.er = er; r.eb = eb; r.et = et;
    return r;
  endfunction

  // Reference model state: input stream plus expected frame contents.
  logic [15:0] in_w[$];
  logic        in_l[$];
  logic [15:0] exp_words[$];
  int          exp_len[$];
  bit          exp_trunc[$];

  function automatic void push_frame(input int n);
    logic [15:0] sum;
    logic [15:0] w;
    int          k;
    sum = 16'h0;
    k = (n > int'(MaxLen)) ? int'(MaxLen) : n;
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      in_w.push_back(w);
      in_l.push_back(i == n - 1);
      if (i < k) begin
        exp_words.push_back(w);
        sum = sum + w;
      end
    end
    exp_words.push_back(sum);
    exp_len.push_back(k);
    exp_trunc.push_back(n > int'(MaxLen));
  endfunction

  // Output stream monitor.
  bit          mon_on = 1'b0;
  bit          in_frame = 1'b0;
  int          gap_run = 0;
  logic [7:0]  exp_seq = 8'd0;
  logic [7:0]  last_seq = 8'd0;
  bit          saw_wrap = 1'b0;
  int          frames_done = 0;
  int          trunc_seen = 0;
  int          trunc_pos = 0;
  logic [15:0] got[$];
  int          m_n;
  bit          m_t;
  logic [15:0] m_w;

  always @(negedge clk) begin
    if (mon_on) begin
      if (!in_frame) begin
        if (tx_charisk && tx_data == IdleW) begin
          gap_run++;
          check("idle_flags", 64'({busy, trunc}), 64'(0));
        end else if (tx_charisk && tx_data[7:0] == 8'hFB) begin
          check("sof_gap", 64'(gap_run >= int'(MinGap)), 64'(1));
          check("sof_seq", 64'(tx_data[15:8]), 64'(exp_seq));
          check("sof_busy", 64'(busy), 64'(1));
          check("sof_expected", 64'(exp_len.size() > 0), 64'(1));
          if (frames_done > 0 && last_seq == 8'hFF && tx_data[15:8] == 8'h00) saw_wrap = 1'b1;
          last_seq   = tx_data[15:8];
          in_frame   = 1'b1;
          trunc_seen = 0;
          trunc_pos  = -1;
          got.delete();
        end else begin
          check("idle_word", 64'({tx_charisk, tx_data}), 64'({1'b1, IdleW}));
        end
      end else begin
        check("frame_busy", 64'(busy), 64'(1));
        if (trunc) begin
          trunc_seen++;
          trunc_pos = tx_charisk ? -2 : got.size() + 1;
        end
        if (!tx_charisk) begin
          got.push_back(tx_data);
        end else if (tx_data == EofW) begin
          if (exp_len.size() == 0) begin
            check("frame_expected", 64'(0), 64'(1));
          end else begin
            m_n = exp_len.pop_front();
            m_t = exp_trunc.pop_front();
            check("frame_len", 64'(got.size()), 64'(m_n + 1));
            for (int i = 0; i <= m_n; i++) begin
              m_w = exp_words.pop_front();
              if (i < got.size()) begin
                if (i == m_n) check("checksum", 64'(got[i]), 64'(m_w));
                else check("payload", 64'(got[i]), 64'(m_w));
              end
            end
            check("trunc_count", 64'(trunc_seen), 64'(m_t));
            if (m_t) check("trunc_pos", 64'(trunc_pos), 64'(MaxLen));
          end
          in_frame = 1'b0;
          gap_run  = 0;
          exp_seq  = exp_seq + 8'd1;
          frames_done++;
        end else if (tx_data != IdleW) begin
          check("frame_kword", 64'(tx_data), 64'(EofW));
        end
      end
    end
  end

  task automatic drive_all(input int unsigned bubble, input bit rand_en);
    bit hs;
    int g;
    hs = 1'b0;
    g = 0;
    while (in_w.size() > 0 && g < 20000) begin
      @(negedge clk);
      g++;
      if (hs) begin
        in_w.delete(0);
        in_l.delete(0);
      end
      hs = 1'b0;
      if (in_w.size() == 0) break;
      en      = rand_en ? ($urandom_range(7) != 0) : 1'b1;
      s_valid = ($urandom_range(99) >= bubble);
      s_data  = in_w[0];
      s_last  = in_l[0];
      #1;
      hs = s_valid && s_ready;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    en      = 1'b1;
    check("drive_done", 64'(in_w.size()), 64'(0));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_len.size() > 0 || in_frame) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("drain", 64'(exp_len.size()), 64'(0));
    repeat (MinGap + 2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit seen;

    tbl.push_back(mk(1, 16'h0001, 0, IdleW,    1, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0001, 0, 16'h00FB, 1, 1, 1, 0));
    tbl.push_back(mk(1, 16'h0002, 0, 16'h0001, 0, 1, 1, 0));
    tbl.push_back(mk(1, 16'hFFFF, 1, 16'h0002, 0, 1, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 16'hFFFF, 0, 0, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0002, 0, 0, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 0, EofW,     1, 0, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 16'h0000, 0, IdleW, 1, 0, 0, 0));
    tbl.push_back(mk(1, 16'h1111, 0, IdleW,    1, 0, 0, 0));
    tbl.push_back(mk(1, 16'h1111, 0, 16'h01FB, 1, 1, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h1111, 0, 1, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 0, IdleW,    1, 1, 1, 0));
    tbl.push_back(mk(1, 16'h2222, 0, IdleW,    1, 1, 1, 0));
    tbl.push_back(mk(1, 16'h3333, 1, 16'h2222, 0, 1, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h3333, 0, 0, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h6666, 0, 0, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 0, EofW,     1, 0, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 16'h0000, 0, IdleW, 1, 0, 0, 0));

    // Reset, then idle with the link enabled.
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", 64'({tx_data, tx_charisk, s_ready, busy, trunc}),
          64'({IdleW, 4'b1000}));
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_after_reset", 64'({tx_data, tx_charisk, s_ready, busy}), 64'({IdleW, 3'b100}));
    end

    // Link disabled: pending data must not start a frame.
    en = 1'b0;
    s_valid = 1'b1;
    s_data = 16'h1234;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("en_low_idle", 64'({tx_data, tx_charisk, s_ready, busy}), 64'({IdleW, 3'b100}));
    end
    s_valid = 1'b0;
    en = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      check($sformatf("vec%0d", i), 64'({tx_data, tx_charisk, s_ready, busy, trunc}),
            64'({tbl[i].ed, tbl[i].ek, tbl[i].er, tbl[i].eb, tbl[i].et}));
      s_valid = tbl[i].v;
      s_data  = tbl[i].d;
      s_last  = tbl[i].l;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;

    // Truncation: 6 words into MAX_LEN=4, then a short follow-up frame.
    in_frame = 1'b0;
    gap_run  = int'(MinGap);
    exp_seq  = 8'd2;
    mon_on   = 1'b1;
    base = frames_done;
    push_frame(6);
    push_frame(2);
    drive_all(0, 1'b0);
    drain();
    check("trunc_frames", 64'(frames_done - base), 64'(2));

    // Exactly MAX_LEN words with s_last: no truncation; then a 1-word frame.
    push_frame(int'(MaxLen));
    push_frame(1);
    drive_all(30, 1'b0);
    drain();

    // Randomized frames, long enough to wrap the sequence number.
    for (int f = 0; f < 260; f++) push_frame(int'($urandom_range(1, 6)));
    drive_all(20, 1'b1);
    drain();
    check("seq_wrap", 64'(saw_wrap), 64'(1));

    // Reset pulsed during DATA aborts the frame.
    mon_on = 1'b0;
    s_valid = 1'b1;
    s_data = 16'hAAAA;
    s_last = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = busy;
    end
    check("abort_start", 64'(seen), 64'(1));
    @(negedge clk);
    check("abort_word", 64'({tx_data, tx_charisk}), 64'({16'hAAAA, 1'b0}));
    rst_n = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("abort_idle", 64'({tx_data, tx_charisk, s_ready, busy, trunc}),
          64'({IdleW, 4'b1000}));
    rst_n = 1'b1;
    in_w.delete();
    in_l.delete();
    exp_words.delete();
    exp_len.delete();
    exp_trunc.delete();
    in_frame = 1'b0;
    gap_run  = 0;
    exp_seq  = 8'd0;
    mon_on   = 1'b1;
    push_frame(3);
    drive_all(0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
